lsu_ctrl: RTL and testbench

Parametrised load/store unit that replaces the zero-latency DPI memory port with a handshaked request/response engine toward a single-port memory bus. It accepts one load or store from the EXU at a time. Misaligned accesses that cross a bus word are split into two bus beats, and the loaded data is merged, aligned and sign/zero-extended before it is returned to WBU. It sits between the EXU memory stage and the memory/AXI-lite bridge.

---
 rtl/lsu_ctrl_if.sv | 58 +++++
 rtl/lsu_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Interfaces for the load/store unit.
//   lsu_req_if : EXU -> LSU request channel plus the LSU -> WBU response channel.
//                master = EXU/WBU side, slave = LSU.
//   lsu_mem_if : LSU -> single-port memory bus, one beat at a time.
//                master = LSU, slave = memory / AXI-lite bridge.
// mem_err is qualified by mem_rvalid. mem_addr is always bus-word aligned.

interface lsu_req_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  mem_req;
   logic                  mem_gnt;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: takes one EXU load or store at a time and turns it into one
// or two handshaked beats on a single-port memory bus. Accesses crossing a bus
// word are split (MISALIGN_EN=1) or rejected with an error (MISALIGN_EN=0).
// Load data from both beats is merged, aligned and sign/zero-extended.
//
// Ports:
//   sys_clk  : clock, rising edge
//   sys_rst  : synchronous active-high reset
//   exu      : lsu_req_if.slave  (req_* in, req_ready/resp_* out, resp_ready in)
//   bus      : lsu_mem_if.master (mem_req/we/addr/wdata/wstrb out, gnt/rvalid/rdata/err in)
//
// All outputs are registers or decodes of the state register.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request (req_ready=1)
// REQ0   | beat 0 on the bus, waiting for mem_gnt
// WAIT0  | beat 0 granted, waiting for mem_rvalid
// REQ1   | beat 1 (next bus word) on the bus, waiting for mem_gnt
// WAIT1  | beat 1 granted, waiting for mem_rvalid
// RESP   | result held on resp_*, waiting for resp_ready

module lsu_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  logic      sys_clk,
   input  logic      sys_rst,
   lsu_req_if.slave  exu,
   lsu_mem_if.master bus
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFS_W = $clog2(BYTES);
   localparam int SW    = 2 * BYTES;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ0,
      ST_WAIT0,
      ST_REQ1,
      ST_WAIT1,
      ST_RESP
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [OFS_W-1:0]  off_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              wen_q;
   logic              cross_q;
   logic [DATA_W-1:0] wdata_hi_q;
   logic [BYTES-1:0]  wstrb_hi_q;
   logic [DATA_W-1:0] rdata0_q;

   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [BYTES-1:0]  mem_wstrb_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] resp_rdata_q;

   // Request decode, evaluated on the accept edge.
   logic [OFS_W-1:0]    off_d;
   logic [ADDR_W-1:0]   base_d;
   int                  nb_d;
   logic                cross_d;
   logic                illegal_d;
   logic                reject_d;
   logic [2*DATA_W-1:0] wlane_d;
   logic [SW-1:0]       smask_d;
   logic [SW-1:0]       strb_d;

   always_comb begin
      off_d     = exu.req_addr[OFS_W-1:0];
      base_d    = {exu.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      nb_d      = 1 << exu.req_size;
      cross_d   = (int'(off_d) + nb_d) > BYTES;
      illegal_d = (exu.req_size == 2'b11) && (DATA_W != 64);
      reject_d  = illegal_d || (cross_d && (MISALIGN_EN == 0));
      // Data and strobes are positioned over two bus words; the upper half
      // only matters for a split access.
      wlane_d   = {{DATA_W{1'b0}}, exu.req_wdata} << {off_d, 3'b000};
      case (exu.req_size)
         2'd0:    smask_d = SW'(1'b1);
         2'd1:    smask_d = SW'(2'b11);
         2'd2:    smask_d = SW'(4'hF);
         default: smask_d = SW'(8'hFF);
      endcase
      strb_d    = smask_d << off_d;
   end

   // Load merge. On a single-beat access the upper word is zero.
   logic [2*DATA_W-1:0] cat_d;
   logic [DATA_W-1:0]   sh_d;
   logic [DATA_W-1:0]   lmask_d;
   logic                sbit_d;
   logic [DATA_W-1:0]   lo_d;
   logic [DATA_W-1:0]   merged_d;

   always_comb begin
      if (state_q == ST_WAIT1) begin
         cat_d = {bus.mem_rdata, rdata0_q};
      end else begin
         cat_d = {{DATA_W{1'b0}}, bus.mem_rdata};
      end
      sh_d = DATA_W'(cat_d >> {off_q, 3'b000});
      case (size_q)
         2'd0: begin
            lmask_d = DATA_W'(8'hFF);
            sbit_d  = sh_d[7];
         end
         2'd1: begin
            lmask_d = DATA_W'(16'hFFFF);
            sbit_d  = sh_d[15];
         end
         2'd2: begin
            lmask_d = DATA_W'(32'hFFFF_FFFF);
            sbit_d  = sh_d[31];
         end
         default: begin
            lmask_d = '1;
            sbit_d  = sh_d[DATA_W-1];
         end
      endcase
      lo_d     = sh_d & lmask_d;
      merged_d = (signed_q && sbit_d) ? (lo_d | ~lmask_d) : lo_d;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         off_q        <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         wen_q        <= 1'b0;
         cross_q      <= 1'b0;
         wdata_hi_q   <= '0;
         wstrb_hi_q   <= '0;
         rdata0_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (exu.req_valid) begin
                  base_q     <= base_d;
                  off_q      <= off_d;
                  size_q     <= exu.req_size;
                  signed_q   <= exu.req_signed;
                  wen_q      <= exu.req_wen;
                  cross_q    <= cross_d;
                  wdata_hi_q <= exu.req_wen ? wlane_d[2*DATA_W-1:DATA_W] : '0;
                  wstrb_hi_q <= exu.req_wen ? strb_d[SW-1:BYTES] : '0;
                  if (reject_d) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q     <= ST_REQ0;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= exu.req_wen;
                     mem_addr_q  <= base_d;
                     mem_wdata_q <= exu.req_wen ? wlane_d[DATA_W-1:0] : '0;
                     mem_wstrb_q <= exu.req_wen ? strb_d[BYTES-1:0] : '0;
                  end
               end
            end

            ST_REQ0: begin
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_WAIT0;
               end
            end

            ST_WAIT0: begin
               if (bus.mem_rvalid) begin
                  if (cross_q && !bus.mem_err) begin
                     rdata0_q    <= bus.mem_rdata;
                     state_q     <= ST_REQ1;
                     mem_req_q   <= 1'b1;
                     mem_addr_q  <= base_q + ADDR_W'(BYTES);
                     mem_wdata_q <= wdata_hi_q;
                     mem_wstrb_q <= wstrb_hi_q;
                  end else begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= bus.mem_err;
                     resp_rdata_q <= (bus.mem_err || wen_q) ? '0 : merged_d;
                  end
               end
            end

            ST_REQ1: begin
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_WAIT1;
               end
            end

            ST_WAIT1: begin
               if (bus.mem_rvalid) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= bus.mem_err;
                  resp_rdata_q <= (bus.mem_err || wen_q) ? '0 : merged_d;
               end
            end

            ST_RESP: begin
               if (exu.resp_ready) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= '0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign exu.req_ready  = (state_q == ST_IDLE);
   assign exu.resp_valid = resp_valid_q;
   assign exu.resp_err   = resp_err_q;
   assign exu.resp_rdata = resp_rdata_q;

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl, DATA_W=32. dut0 splits crossing accesses,
// dut1 rejects them. Inputs change and outputs are sampled on the falling edge.

module tb_lsu_ctrl;

   logic sys_clk;
   logic sys_rst;
   int   n_vec;
   int   n_err;

   lsu_req_if #(.DATA_W(32), .ADDR_W(32)) r0 ();
   lsu_mem_if #(.DATA_W(32), .ADDR_W(32)) m0 ();
   lsu_req_if #(.DATA_W(32), .ADDR_W(32)) r1 ();
   lsu_mem_if #(.DATA_W(32), .ADDR_W(32)) m1 ();

   lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1)) dut0 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .exu     (r0),
      .bus     (m0)
   );

   lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(0)) dut1 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .exu     (r1),
      .bus     (m1)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
      chk("req_ready_idle", r0.req_ready, 1);
      r0.req_valid  = 1'b1;
      r0.req_wen    = wen;
      r0.req_addr   = addr;
      r0.req_size   = size;
      r0.req_signed = sgn;
      r0.req_wdata  = wdata;
      tick();
      r0.req_valid  = 1'b0;
   endtask

   // One bus beat: grant at once, rvalid on the following cycle.
   task automatic beat(input string tag, input logic [31:0] e_addr, input logic e_we,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] rd, input logic err);
      chk({tag, "_mem_req"}, m0.mem_req, 1);
      chk({tag, "_mem_addr"}, m0.mem_addr, e_addr);
      chk({tag, "_mem_we"}, m0.mem_we, e_we);
      chk({tag, "_mem_wstrb"}, m0.mem_wstrb, e_strb);
      if (e_we) chk({tag, "_mem_wdata"}, m0.mem_wdata, e_wdata);
      chk({tag, "_req_ready_busy"}, r0.req_ready, 0);
      m0.mem_gnt = 1'b1;
      tick();
      m0.mem_gnt = 1'b0;
      chk({tag, "_mem_req_drop"}, m0.mem_req, 0);
      m0.mem_rvalid = 1'b1;
      m0.mem_rdata  = rd;
      m0.mem_err    = err;
      tick();
      m0.mem_rvalid = 1'b0;
      m0.mem_rdata  = '0;
      m0.mem_err    = 1'b0;
   endtask

   task automatic resp(input string tag, input logic [31:0] e_rdata, input logic e_err);
      chk({tag, "_resp_valid"}, r0.resp_valid, 1);
      chk({tag, "_resp_rdata"}, r0.resp_rdata, e_rdata);
      chk({tag, "_resp_err"}, r0.resp_err, e_err);
      r0.resp_ready = 1'b1;
      tick();
      r0.resp_ready = 1'b0;
      chk({tag, "_resp_valid_drop"}, r0.resp_valid, 0);
      chk({tag, "_req_ready_back"}, r0.req_ready, 1);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      sys_rst = 1'b1;
      r0.req_valid = 1'b0; r0.req_wen = 1'b0; r0.req_addr = '0; r0.req_size = '0;
      r0.req_signed = 1'b0; r0.req_wdata = '0; r0.resp_ready = 1'b0;
      r1.req_valid = 1'b0; r1.req_wen = 1'b0; r1.req_addr = '0; r1.req_size = '0;
      r1.req_signed = 1'b0; r1.req_wdata = '0; r1.resp_ready = 1'b0;
      m0.mem_gnt = 1'b0; m0.mem_rvalid = 1'b0; m0.mem_rdata = '0; m0.mem_err = 1'b0;
      m1.mem_gnt = 1'b0; m1.mem_rvalid = 1'b0; m1.mem_rdata = '0; m1.mem_err = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // Reset values
      chk("rst_req_ready", r0.req_ready, 1);
      chk("rst_mem_req", m0.mem_req, 0);
      chk("rst_mem_we", m0.mem_we, 0);
      chk("rst_mem_wstrb", m0.mem_wstrb, 0);
      chk("rst_mem_addr", m0.mem_addr, 0);
      chk("rst_mem_wdata", m0.mem_wdata, 0);
      chk("rst_resp_valid", r0.resp_valid, 0);
      chk("rst_resp_err", r0.resp_err, 0);
      chk("rst_resp_rdata", r0.resp_rdata, 0);

      // Aligned word load, minimum latency (resp_valid 3 cycles after accept)
      send(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
      beat("ldw", 32'h8000_0004, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
      resp("ldw", 32'hDEAD_BEEF, 1'b0);

      // Byte load from lane 3, signed then unsigned
      send(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0);
      beat("ldbs", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h8000_0000, 1'b0);
      resp("ldbs", 32'hFFFF_FF80, 1'b0);
      send(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0);
      beat("ldbu", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h8000_0000, 1'b0);
      resp("ldbu", 32'h0000_0080, 1'b0);

      // Signed half ending exactly at the word boundary: one beat, positive value
      send(1'b0, 32'h8000_0002, 2'd1, 1'b1, 32'h0);
      beat("ldhs", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h7FFE_1234, 1'b0);
      resp("ldhs", 32'h0000_7FFE, 1'b0);

      // Misaligned half store split across two words
      send(1'b1, 32'h8000_0003, 2'd1, 1'b0, 32'h0000_ABCD);
      beat("sth0", 32'h8000_0000, 1'b1, 4'b1000, 32'hCD00_0000, 32'h0, 1'b0);
      beat("sth1", 32'h8000_0004, 1'b1, 4'b0001, 32'h0000_00AB, 32'h0, 1'b0);
      resp("sth", 32'h0, 1'b0);

      // Misaligned word load split across two words
      send(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
      beat("ldm0", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h4433_2211, 1'b0);
      beat("ldm1", 32'h8000_0004, 1'b0, 4'b0000, 32'h0, 32'h8877_6655, 1'b0);
      resp("ldm", 32'h6655_4433, 1'b0);

      // Aligned word store
      send(1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678);
      beat("stw", 32'h8000_0008, 1'b1, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
      resp("stw", 32'h0, 1'b0);

      // Grant withheld 5 cycles, then response held off 3 cycles
      send(1'b1, 32'h8000_0011, 2'd0, 1'b0, 32'h0000_005A);
      for (int i = 0; i < 5; i++) begin
         chk("bp_mem_req", m0.mem_req, 1);
         chk("bp_mem_addr", m0.mem_addr, 32'h8000_0010);
         chk("bp_mem_wstrb", m0.mem_wstrb, 4'b0010);
         chk("bp_mem_wdata", m0.mem_wdata, 32'h0000_5A00);
         tick();
      end
      beat("bp", 32'h8000_0010, 1'b1, 4'b0010, 32'h0000_5A00, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_resp_hold_valid", r0.resp_valid, 1);
         chk("bp_resp_hold_err", r0.resp_err, 0);
         chk("bp_req_ready_low", r0.req_ready, 0);
         tick();
      end
      resp("bp", 32'h0, 1'b0);

      // Load response held under backpressure
      send(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0);
      beat("bpl", 32'h8000_0010, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bpl_resp_hold_rdata", r0.resp_rdata, 32'h0BAD_F00D);
         tick();
      end
      resp("bpl", 32'h0BAD_F00D, 1'b0);

      // Bus error on beat 0 of a split: no second beat
      send(1'b0, 32'h8000_0006, 2'd2, 1'b0, 32'h0);
      beat("err0", 32'h8000_0004, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FFFF, 1'b1);
      chk("err0_no_beat1", m0.mem_req, 0);
      resp("err0", 32'h0, 1'b1);

      // Illegal size: error one cycle after accept, no bus beat
      send(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0);
      chk("ill_no_mem_req", m0.mem_req, 0);
      resp("ill", 32'h0, 1'b1);

      // Stray rvalid in IDLE is ignored
      m0.mem_rvalid = 1'b1;
      m0.mem_rdata  = 32'h1111_1111;
      tick();
      m0.mem_rvalid = 1'b0;
      m0.mem_rdata  = '0;
      chk("stray_resp_valid", r0.resp_valid, 0);
      chk("stray_req_ready", r0.req_ready, 1);

      // MISALIGN_EN=0: crossing access rejected without a bus beat
      chk("nm_req_ready", r1.req_ready, 1);
      r1.req_valid = 1'b1;
      r1.req_addr  = 32'h8000_0002;
      r1.req_size  = 2'd2;
      tick();
      r1.req_valid = 1'b0;
      chk("nm_mem_req", m1.mem_req, 0);
      chk("nm_resp_valid", r1.resp_valid, 1);
      chk("nm_resp_err", r1.resp_err, 1);
      chk("nm_resp_rdata", r1.resp_rdata, 0);
      r1.resp_ready = 1'b1;
      tick();
      r1.resp_ready = 1'b0;
      chk("nm_req_ready_back", r1.req_ready, 1);
      chk("nm_mem_req_after", m1.mem_req, 0);

      // Reset while in WAIT1, then a normal access
      send(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
      beat("rw0", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h4433_2211, 1'b0);
      chk("rw_beat1_req", m0.mem_req, 1);
      chk("rw_beat1_addr", m0.mem_addr, 32'h8000_0004);
      m0.mem_gnt = 1'b1;
      tick();
      m0.mem_gnt = 1'b0;
      chk("rw_in_wait1", m0.mem_req, 0);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      chk("rw_req_ready", r0.req_ready, 1);
      chk("rw_mem_req", m0.mem_req, 0);
      chk("rw_resp_valid", r0.resp_valid, 0);
      chk("rw_mem_addr", m0.mem_addr, 0);
      send(1'b0, 32'h8000_0000, 2'd2, 1'b1, 32'h0);
      beat("rwn", 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'hCAFE_BABE, 1'b0);
      resp("rwn", 32'hCAFE_BABE, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
